word_guess_datapath: RTL and testbench

// Datapath consumer of the hangman control FSM. Stores the secret word entered

---
 rtl/word_guess_datapath.sv | 161 ++++++++++++++++
 tb/tb_word_guess_datapath.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/word_guess_datapath.sv
// Word-guess game datapath: holds the secret word, scans each guess one position
// per cycle, tracks revealed positions and the miss count for the hangman controller.
module word_guess_datapath #(
  parameter int MAX_LEN    = 8,
  parameter int CHAR_W     = 5,
  parameter int MAX_MISSES = 6
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ld,
  input  logic                       char_valid,
  input  logic [CHAR_W-1:0]          char_in,
  input  logic                       compare,
  input  logic                       guess_valid,
  input  logic [CHAR_W-1:0]          guess_in,
  input  logic                       wipe,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
  output logic [CHAR_W-1:0]          rd_char,
  output logic                       busy,
  output logic                       result_valid,
  output logic                       match,
  output logic [3:0]                 miss_count,
  output logic [3:0]                 word_len,
  output logic [MAX_LEN-1:0]         revealed,
  output logic                       cont,
  output logic                       complete
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = 4;
  localparam logic [CHAR_W-1:0] MAX_CODE = CHAR_W'(25);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_READY  = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]         state_reg;
  logic [CHAR_W-1:0]  word_mem_reg [MAX_LEN];
  logic [LEN_W-1:0]   word_len_reg;
  logic [CHAR_W-1:0]  guess_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               hit_reg;
  logic [MAX_LEN-1:0] revealed_reg;
  logic [LEN_W-1:0]   miss_count_reg;
  logic               match_reg;
  logic               cont_reg;
  logic               complete_reg;

  logic               load_we;
  logic               scan_hit;
  logic               hit_next;
  logic               last_idx;
  logic [MAX_LEN-1:0] revealed_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   miss_count_next;

  assign load_we  = (state_reg == S_LOAD) && ld && char_valid &&
                    (char_in <= MAX_CODE) && (word_len_reg < LEN_W'(MAX_LEN));
  assign scan_hit = (word_mem_reg[idx_reg] == guess_reg);
  assign hit_next = hit_reg | scan_hit;
  assign last_idx = (LEN_W'(idx_reg) == word_len_reg - LEN_W'(1));

  always_comb begin
    revealed_next = revealed_reg;
    if (scan_hit)
      revealed_next[idx_reg] = 1'b1;
  end

  // Positions beyond the stored word never count as hidden.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_len_mask
      assign len_mask[gi] = (LEN_W'(gi) < word_len_reg);
    end
  endgenerate

  assign miss_count_next = (!hit_next && miss_count_reg < LEN_W'(MAX_MISSES)) ?
                           miss_count_reg + LEN_W'(1) : miss_count_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_LEN; i++) word_mem_reg[i] <= '0;
    end else if (wipe) begin
      for (int i = 0; i < MAX_LEN; i++) word_mem_reg[i] <= '0;
    end else if (load_we) begin
      word_mem_reg[word_len_reg[IDX_W-1:0]] <= char_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      word_len_reg   <= '0;
      guess_reg      <= '0;
      idx_reg        <= '0;
      hit_reg        <= 1'b0;
      revealed_reg   <= '0;
      miss_count_reg <= '0;
      match_reg      <= 1'b0;
      cont_reg       <= 1'b0;
      complete_reg   <= 1'b0;
    end else if (wipe) begin
      state_reg      <= S_IDLE;
      word_len_reg   <= '0;
      guess_reg      <= '0;
      idx_reg        <= '0;
      hit_reg        <= 1'b0;
      revealed_reg   <= '0;
      miss_count_reg <= '0;
      match_reg      <= 1'b0;
      cont_reg       <= 1'b0;
      complete_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (ld) state_reg <= S_LOAD;
        S_LOAD: begin
          if (!ld)
            state_reg <= (word_len_reg != '0) ? S_READY : S_IDLE;
          else if (load_we)
            word_len_reg <= word_len_reg + LEN_W'(1);
        end
        S_READY: begin
          if (compare && guess_valid && guess_in <= MAX_CODE) begin
            guess_reg <= guess_in;
            hit_reg   <= 1'b0;
            idx_reg   <= '0;
            state_reg <= S_SCAN;
          end
        end
        S_SCAN: begin
          hit_reg      <= hit_next;
          revealed_reg <= revealed_next;
          idx_reg      <= idx_reg + IDX_W'(1);
          // Result registers load on the last scan edge so they are valid in RESULT.
          if (last_idx) begin
            state_reg      <= S_RESULT;
            match_reg      <= hit_next;
            miss_count_reg <= miss_count_next;
            cont_reg       <= |(len_mask & ~revealed_next);
            complete_reg   <= (miss_count_next == LEN_W'(MAX_MISSES));
          end
        end
        S_RESULT: state_reg <= S_READY;
        default:  state_reg <= S_IDLE;
      endcase
    end
  end

  assign rd_char      = (LEN_W'(rd_idx) < word_len_reg) ? word_mem_reg[rd_idx] : '0;
  assign busy         = (state_reg == S_SCAN);
  assign result_valid = (state_reg == S_RESULT);
  assign match        = match_reg;
  assign miss_count   = miss_count_reg;
  assign word_len     = word_len_reg;
  assign revealed     = revealed_reg;
  assign cont         = cont_reg;
  assign complete     = complete_reg;

endmodule

// File: tb/tb_word_guess_datapath.sv
// Directed bench for word_guess_datapath: hand-computed expectations per guess.
module tb_word_guess_datapath;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ld, char_valid, compare, guess_valid, wipe;
  logic [4:0] char_in, guess_in, rd_char;
  logic [2:0] rd_idx;
  logic       busy, result_valid, match, cont, complete;
  logic [3:0] miss_count, word_len;
  logic [7:0] revealed;

  int tests = 0;
  int fails = 0;
  int load_q[$];

  always #5 clk = ~clk;

  word_guess_datapath dut (
    .clk(clk), .resetn(resetn), .ld(ld), .char_valid(char_valid), .char_in(char_in),
    .compare(compare), .guess_valid(guess_valid), .guess_in(guess_in), .wipe(wipe),
    .rd_idx(rd_idx), .rd_char(rd_char), .busy(busy), .result_valid(result_valid),
    .match(match), .miss_count(miss_count), .word_len(word_len), .revealed(revealed),
    .cont(cont), .complete(complete)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " result_valid"}, 32'(result_valid), 0);
    chk({tag, " word_len"}, 32'(word_len), 0);
    chk({tag, " revealed"}, 32'(revealed), 0);
    chk({tag, " miss_count"}, 32'(miss_count), 0);
    chk({tag, " match"}, 32'(match), 0);
    chk({tag, " cont"}, 32'(cont), 0);
    chk({tag, " complete"}, 32'(complete), 0);
  endtask

  // Enters LOAD, streams load_q one code per cycle, then drops ld.
  task automatic load_word();
    ld = 1'b1;
    @(negedge clk);
    foreach (load_q[i]) begin
      char_valid = 1'b1;
      char_in    = 5'(load_q[i]);
      @(negedge clk);
    end
    char_valid = 1'b0;
    ld = 1'b0;
    @(negedge clk);
  endtask

  task automatic guess(input string tag, input int g, input int wl, input int e_match,
                       input int e_miss, input int e_rev, input int e_cont, input int e_cmp);
    int k;
    $display("[TB] guess %0d (%s)", g, tag);
    guess_valid = 1'b1;
    guess_in    = 5'(g);
    @(negedge clk);
    guess_valid = 1'b0;
    k = 1;
    chk({tag, " busy"}, 32'(busy), 1);
    while (!result_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(wl + 1));
    chk({tag, " match"}, 32'(match), 32'(e_match));
    chk({tag, " miss_count"}, 32'(miss_count), 32'(e_miss));
    chk({tag, " revealed"}, 32'(revealed), 32'(e_rev));
    chk({tag, " cont"}, 32'(cont), 32'(e_cont));
    chk({tag, " complete"}, 32'(complete), 32'(e_cmp));
    @(negedge clk);
    chk({tag, " rv pulse"}, 32'(result_valid), 0);
  endtask

  initial begin
    resetn = 1'b0; ld = 0; char_valid = 0; char_in = 0; compare = 0;
    guess_valid = 0; guess_in = 0; wipe = 0; rd_idx = 0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    chk("reset rd_char", 32'(rd_char), 0);
    resetn = 1'b1;
    @(negedge clk);

    // C,A,T
    load_q = '{2, 0, 19};
    load_word();
    chk("cat word_len", 32'(word_len), 3);
    rd_idx = 3'd2; #1 chk("cat rd 2", 32'(rd_char), 19);
    rd_idx = 3'd3; #1 chk("cat rd 3 beyond", 32'(rd_char), 0);
    compare = 1'b1;
    guess("g A",  0, 3, 1, 0, 8'b0000_0010, 1, 0);
    guess("g Z", 25, 3, 0, 1, 8'b0000_0010, 1, 0);
    guess("g A2", 0, 3, 1, 1, 8'b0000_0010, 1, 0);
    guess("g C",  2, 3, 1, 1, 8'b0000_0011, 1, 0);
    guess("g T", 19, 3, 1, 1, 8'b0000_0111, 0, 0);

    // guess with compare low, invalid guess, and ld in READY are all ignored
    compare = 1'b0; guess_valid = 1'b1; guess_in = 5'd0;
    @(negedge clk);
    compare = 1'b1; guess_in = 5'd27;
    @(negedge clk);
    guess_valid = 1'b0; ld = 1'b1; char_valid = 1'b1; char_in = 5'd4;
    repeat (3) @(negedge clk);
    chk("ignored busy", 32'(busy), 0);
    chk("ignored rv", 32'(result_valid), 0);
    chk("ld in READY word_len", 32'(word_len), 3);
    ld = 1'b0; char_valid = 1'b0;
    @(negedge clk);

    // overflow and invalid code during load
    wipe = 1'b1; @(negedge clk); wipe = 1'b0;
    check_cleared("wipe1");
    load_q = '{1, 2, 3, 30, 4, 5, 6, 7, 8, 9, 10};
    load_word();
    chk("ovf word_len", 32'(word_len), 8);
    rd_idx = 3'd7; #1 chk("ovf rd 7", 32'(rd_char), 8);
    rd_idx = 3'd3; #1 chk("ovf rd 3", 32'(rd_char), 4);
    for (int m = 1; m <= 7; m++)
      guess($sformatf("miss%0d", m), 25, 8, 0, (m > 6) ? 6 : m, 0, 1, (m >= 6) ? 1 : 0);

    // wipe in the middle of a scan
    wipe = 1'b1; @(negedge clk); wipe = 1'b0;
    load_q = '{0, 1, 2, 3, 4};
    load_word();
    chk("five word_len", 32'(word_len), 5);
    guess_valid = 1'b1; guess_in = 5'd0;
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
    chk("mid-scan busy", 32'(busy), 1);
    wipe = 1'b1;
    @(negedge clk);
    wipe = 1'b0;
    check_cleared("wipe scan");
    repeat (6) @(negedge clk);
    chk("post-wipe no result", 32'(result_valid), 0);
    load_q = '{2, 0, 19};
    load_word();
    guess("after wipe T", 19, 3, 1, 0, 8'b0000_0100, 1, 0);

    // async reset pulsed mid-load
    ld = 1'b1;
    @(negedge clk);
    chk("ld ignored outside IDLE", 32'(word_len), 3);
    wipe = 1'b1; @(negedge clk); wipe = 1'b0;
    @(negedge clk);
    char_valid = 1'b1; char_in = 5'd7;
    @(negedge clk);
    chk("midload word_len", 32'(word_len), 1);
    char_valid = 1'b0;
    #2 resetn = 1'b0;
    #1 check_cleared("async reset");
    ld = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    load_q = '{11, 4};
    load_word();
    chk("reload word_len", 32'(word_len), 2);
    rd_idx = 3'd0; #1 chk("reload rd 0", 32'(rd_char), 11);
    guess("reload E", 4, 2, 1, 0, 8'b0000_0010, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
